// File: rtl/sequenciador_rodadas_if.sv
// Signal bundle between the round sequencer and its environment (game controller and front panel).
interface sequenciador_rodadas_if;
  logic       iniciar;
  logic [1:0] nivel_dificuldade;
  logic       ganhou_ponto;
  logic       perdeu_ponto;
  logic [2:0] position_led;
  logic       conta_nivel;
  logic       reset_nivel;
  logic       reset_ponto;
  logic [7:0] rodada;
  logic [7:0] rodadas_ganhas;
  logic       ultimo_ganhou;
  logic       jogando;
  logic       fim_jogo;

  modport master (
    output iniciar, nivel_dificuldade, ganhou_ponto, perdeu_ponto,
    input  position_led, conta_nivel, reset_nivel, reset_ponto,
    input  rodada, rodadas_ganhas, ultimo_ganhou, jogando, fim_jogo
  );

  modport slave (
    input  iniciar, nivel_dificuldade, ganhou_ponto, perdeu_ponto,
    output position_led, conta_nivel, reset_nivel, reset_ponto,
    output rodada, rodadas_ganhas, ultimo_ganhou, jogando, fim_jogo
  );
endinterface

// File: rtl/sequenciador_rodadas.sv
// Round sequencer: game flow FSM, 1 kHz level tick, pseudo-random target per round
// and round/score bookkeeping in front of the game controller.
module sequenciador_rodadas #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned PAUSE_TICKS = 500,
  parameter int unsigned GAME_ROUNDS = 20,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset,
  sequenciador_rodadas_if.slave  bus
);

  localparam int unsigned DIV_W    = $clog2(TICK_DIV);
  localparam int unsigned PAU_W    = $clog2(PAUSE_TICKS + 1);
  localparam int unsigned HALF     = ((PAUSE_TICKS / 2) < 1) ? 1 : (PAUSE_TICKS / 2);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [PAU_W-1:0] LEN_FULL = PAU_W'(PAUSE_TICKS);
  localparam logic [PAU_W-1:0] LEN_HALF = PAU_W'(HALF);
  localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]       ROUNDS   = 8'(GAME_ROUNDS);

  typedef enum logic [2:0] {OCIOSO, PREPARA, JOGANDO, PAUSA, FIM} estado_t;

  estado_t          state_q;
  logic [7:0]       lfsr_q;
  logic [DIV_W-1:0] div_q;
  logic [PAU_W-1:0] pausa_q;
  logic [PAU_W-1:0] pausa_len_q;
  logic [2:0]       pos_q;
  logic             conta_q;
  logic             reset_nivel_q;
  logic             reset_ponto_q;
  logic [7:0]       rodada_q;
  logic [7:0]       ganhas_q;
  logic             ultimo_q;
  logic             jogando_q;
  logic             fim_q;

  logic             lfsr_fb;
  logic             tick;
  logic             resultado;
  logic             ultima_rodada;
  logic [2:0]       cand;
  logic [2:0]       pick;
  logic [DIV_W-1:0] div_next;
  logic [PAU_W-1:0] pausa_inc;
  logic [7:0]       rodada_inc;

  assign lfsr_fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign tick          = (div_q == DIV_MAX);
  assign div_next      = tick ? '0 : div_q + DIV_W'(1);
  assign pausa_inc     = pausa_q + PAU_W'(1);
  assign resultado     = bus.ganhou_ponto | bus.perdeu_ponto;
  assign rodada_inc    = rodada_q + 8'd1;
  assign ultima_rodada = (rodada_inc == ROUNDS);
  // Bump a colliding candidate so the target never repeats between rounds
  assign cand          = lfsr_q[2:0];
  assign pick          = (cand == pos_q) ? cand + 3'd1 : cand;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= OCIOSO;
      lfsr_q        <= SEED;
      div_q         <= '0;
      pausa_q       <= '0;
      pausa_len_q   <= LEN_FULL;
      pos_q         <= 3'd0;
      conta_q       <= 1'b0;
      reset_nivel_q <= 1'b1;
      reset_ponto_q <= 1'b0;
      rodada_q      <= 8'd0;
      ganhas_q      <= 8'd0;
      ultimo_q      <= 1'b0;
      jogando_q     <= 1'b0;
      fim_q         <= 1'b0;
    end else begin
      lfsr_q        <= {lfsr_q[6:0], lfsr_fb};
      conta_q       <= 1'b0;
      reset_ponto_q <= 1'b0;
      case (state_q)
        OCIOSO, FIM: begin
          if (bus.iniciar) begin
            state_q       <= PREPARA;
            reset_ponto_q <= 1'b1;
            reset_nivel_q <= 1'b1;
            fim_q         <= 1'b0;
            rodada_q      <= 8'd0;
            ganhas_q      <= 8'd0;
            ultimo_q      <= 1'b0;
          end
        end
        PREPARA: begin
          state_q       <= JOGANDO;
          pos_q         <= pick;
          div_q         <= '0;
          reset_nivel_q <= 1'b0;
          jogando_q     <= 1'b1;
        end
        JOGANDO: begin
          div_q <= div_next;
          if (resultado) begin
            // Closing clock suppresses the level tick even on a divider wrap
            rodada_q      <= rodada_inc;
            ultimo_q      <= bus.ganhou_ponto;
            ganhas_q      <= ganhas_q + 8'(bus.ganhou_ponto);
            reset_nivel_q <= 1'b1;
            if (ultima_rodada) begin
              state_q   <= FIM;
              jogando_q <= 1'b0;
              fim_q     <= 1'b1;
            end else begin
              state_q     <= PAUSA;
              pausa_q     <= '0;
              pausa_len_q <= bus.nivel_dificuldade[1] ? LEN_HALF : LEN_FULL;
            end
          end else begin
            conta_q <= tick;
          end
        end
        PAUSA: begin
          div_q <= div_next;
          if (tick) begin
            if (pausa_inc == pausa_len_q) begin
              state_q       <= JOGANDO;
              pos_q         <= pick;
              div_q         <= '0;
              reset_nivel_q <= 1'b0;
            end else begin
              pausa_q <= pausa_inc;
            end
          end
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign bus.position_led   = pos_q;
  assign bus.conta_nivel    = conta_q;
  assign bus.reset_nivel    = reset_nivel_q;
  assign bus.reset_ponto    = reset_ponto_q;
  assign bus.rodada         = rodada_q;
  assign bus.rodadas_ganhas = ganhas_q;
  assign bus.ultimo_ganhou  = ultimo_q;
  assign bus.jogando        = jogando_q;
  assign bus.fim_jogo       = fim_q;

endmodule

// File: doc/sequenciador_rodadas.md
# sequenciador_rodadas

Round sequencer sitting directly upstream of the game controller. It owns the game flow: start, rounds, pauses and end of game. It generates the 1 kHz `conta_nivel` tick, picks a new pseudo-random target `position_led` for every round, and drives `reset_nivel`/`reset_ponto`. It consumes the controller's `ganhou_ponto`/`perdeu_ponto` results to close each round.

## Interface
- `TICK_DIV`, 50000: clocks per `conta_nivel` tick (50 MHz → 1 kHz); ≥2.
- `PAUSE_TICKS`, 500: ticks of pause between rounds at levels 0/1.
- `GAME_ROUNDS`, 20: rounds per game; 1..255.
- `LFSR_SEED`, 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start request, level or pulse, sampled each clock.
- `nivel_dificuldade` in 2: difficulty, sampled when a pause is entered.
- `ganhou_ponto` in 1: round won (from controller).
- `perdeu_ponto` in 1: round lost (from controller).
- `position_led` out 3: current target LED index 0..7.
- `conta_nivel` out 1: one-clock tick pulse, only in JOGANDO.
- `reset_nivel` out 1: level-held clear for the controller's round counters.
- `reset_ponto` out 1: one-clock score clear at game start.
- `rodada` out 8: rounds completed in the current game.
- `rodadas_ganhas` out 8: rounds won in the current game.
- `ultimo_ganhou` out 1: result of the last closed round (1 = won).
- `jogando` out 1: high in JOGANDO and PAUSA.
- `fim_jogo` out 1: high in FIM.

## Operation
- FSM states: OCIOSO, PREPARA, JOGANDO, PAUSA, FIM.
- **OCIOSO**: `reset_nivel`=1. On `iniciar`=1 → PREPARA.
- **PREPARA** (exactly 1 clock):
  - `reset_ponto`=1, `reset_nivel`=1.
  - `rodada`, `rodadas_ganhas` and `ultimo_ganhou` ← 0.
  - `position_led` ← pick.
  - Divider ← 0. → JOGANDO.
- **JOGANDO**:
  - `reset_nivel`=0. Divider counts 0..TICK_DIV-1; `conta_nivel`=1 in the clock where divider==TICK_DIV-1.
  - The first clock with `ganhou_ponto`|`perdeu_ponto` high closes the round:
    - `rodada`+1.
    - `ultimo_ganhou` ← `ganhou_ponto`.
    - `rodadas_ganhas`+1 if won.
  - After closing: if new `rodada`==GAME_ROUNDS → FIM; else → PAUSA with the pause counter ← 0.
  - Both result inputs high in the same clock counts as won.
- **PAUSA**:
  - `reset_nivel`=1, `conta_nivel`=0. Divider keeps running; pause counter increments on each internal tick.
  - Pause length is PAUSE_TICKS for level 0/1 and PAUSE_TICKS/2 (floor, min 1) for level 2/3, latched on entry.
  - When the counter reaches the length: `position_led` ← pick, divider ← 0 → JOGANDO.
- **FIM**: `reset_nivel`=1. Counters hold their final values. On `iniciar`=1 → PREPARA.
- Inputs are ignored outside these rules:
  - `iniciar` is ignored in JOGANDO and PAUSA.
  - Result inputs are ignored outside JOGANDO.
- **LFSR**: 8-bit Fibonacci, taps 8,6,5,4. Steps every clock in every state, so press timing adds entropy.
- **Pick**: candidate = LFSR[2:0]. If candidate == current `position_led`, use (candidate+1) mod 8. The target is never repeated between consecutive rounds; the first pick of a game is compared against the pre-game value.
- **Arithmetic**: `rodada`/`rodadas_ganhas` are 8-bit and cannot exceed GAME_ROUNDS, so no wrap. Divider width is $clog2(TICK_DIV); pause counter width is $clog2(PAUSE_TICKS+1).

## Timing
- Reset values:
  - FSM = OCIOSO.
  - `position_led`=0, `conta_nivel`=0, `reset_nivel`=1, `reset_ponto`=0.
  - `rodada`=0, `rodadas_ganhas`=0, `ultimo_ganhou`=0.
  - `jogando`=0, `fim_jogo`=0.
  - LFSR=LFSR_SEED; divider and pause counter = 0.
- All outputs are registered; state-decoded outputs change in the clock after the transition edge.
- `iniciar` high at edge N: PREPARA during cycle N+1 (`reset_ponto`=1), JOGANDO from N+2. The first `conta_nivel` follows TICK_DIV clocks after entering JOGANDO.
- Result input high at edge N in JOGANDO:
  - From N+1: `rodada` updated and `reset_nivel`=1.
  - No `conta_nivel` pulse at N+1, even if the divider would have wrapped.
- Result inputs held high for several clocks close only one round; they are ignored in PAUSA/FIM.
- `reset` mid-game returns everything to reset values at the next edge, overriding any simultaneous `iniciar` or result input.

## Test plan
Bench parameters: TICK_DIV=4, PAUSE_TICKS=3, GAME_ROUNDS=3, LFSR_SEED=8'hA5.

- **Reset**: assert `reset` 2 clocks → all outputs at reset values; `reset_nivel`=1; `position_led`=0.
- **Start and tick**: pulse `iniciar` → `reset_ponto` one clock; `jogando`=1 two clocks after the pulse. `conta_nivel` pulses every 4th clock, never 2 consecutive clocks.
- **Win, pause, new target**:
  - Stimulus: `ganhou_ponto` held high 5 clocks.
  - Required: `rodada`=1, `rodadas_ganhas`=1, `ultimo_ganhou`=1.
  - PAUSA lasts 12 clocks at level 0 and 4 clocks (1 tick × 4) at level 3.
  - The new `position_led` differs from the previous one.
- **Simultaneous and ignored events**:
  - Stimulus 1: `ganhou_ponto`=`perdeu_ponto`=1 in the same clock → counted as won.
  - Stimulus 2: `perdeu_ponto` pulsed during PAUSA → no count change.
- **Game end and restart**:
  - After 3 closed rounds (W, L, W): `fim_jogo`=1, `rodada`=3, `rodadas_ganhas`=2, `reset_nivel`=1, values held.
  - Then `iniciar` → counters return to 0 and a new game starts.
- **Reset mid-game**: `reset` asserted in JOGANDO with `ganhou_ponto`=1 → OCIOSO, `rodada`=0, no round counted.
